// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant + response-valid bus used by if_fetch_unit.
// master: fetch unit (drives request and address).
// slave:  instruction memory (drives grant, response valid and data).
interface if_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues in-order requests
// to instruction memory, buffers responses in a small FIFO and presents
// {PC, PC+4, instruction} to IF/ID. Handles stalls, redirects and discards
// stale in-flight responses.
// Optional macro IF_PERF_CNT_EN adds fetch_bubble_cnt_o, a wrapping count of
// cycles where IF/ID could accept but the FIFO was empty.

// Simulation-only invariants of the fetch credit scheme.
module if_fetch_unit_chk #(
  parameter int BUF_DEPTH = 2,
  parameter int CW        = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          i_push,
  input logic          i_pop,
  input logic          i_rvalid,
  input logic [CW-1:0] i_cnt,
  input logic [CW-1:0] i_out,
  input logic [CW-1:0] i_disc
);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (i_cnt == FULL)));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, i_out} + {1'b0, i_cnt}) <= {1'b0, FULL}));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(i_rvalid && (i_out == {CW{1'b0}})));
  a_discard_le_out: assert property (@(posedge clk) disable iff (rst)
    (i_disc <= i_out));
endmodule

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  if_fetch_unit_if.master        imem,
  output logic                   if_valid_o,
  output logic [31:0]            if_pc_o,
  output logic [31:0]            if_pc4_o,
  output logic [31:0]            if_instr_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_bubble_cnt_o
`endif
);
  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam int          PW      = $clog2(BUF_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   r_req_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_rst_q;
  logic [31:0]   r_fifo_pc    [BUF_DEPTH];
  logic [31:0]   r_fifo_instr [BUF_DEPTH];

  logic [CW:0]   w_credit;
  logic          w_req;
  logic          w_grant;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW-1:0] w_out_next;
  logic [31:0]   w_redirect_pc;
  logic          w_unused_pc_bits;

  // Low address bits of the redirect target are architecturally ignored.
  assign w_redirect_pc    = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_pc_bits = ^redirect_pc_i[1:0];

  // Credit check, handshake qualification and outstanding-count arithmetic.
  always_comb begin
    w_credit   = {1'b0, r_out} + {1'b0, r_cnt};
    w_req      = !rst && (w_credit < DEPTH_W);
    w_grant    = w_req && imem.imem_gnt_i;
    // A response in a redirect cycle belongs to the old stream.
    w_drop     = imem.imem_rvalid_i && ((r_disc != {CW{1'b0}}) || redirect_i);
    w_push     = imem.imem_rvalid_i && !w_drop && !rst;
    w_valid    = (r_cnt != {CW{1'b0}});
    w_pop      = w_valid && !stall_i && !redirect_i && !rst;
    w_out_next = r_out + CW'(w_grant) - CW'(imem.imem_rvalid_i);
  end

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = r_req_pc;

  // Fetch/response PCs, credit counters and FIFO pointers.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_req_pc  <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_cnt     <= {CW{1'b0}};
      r_rd_ptr  <= {PW{1'b0}};
      r_wr_ptr  <= {PW{1'b0}};
      // Requests granted before a short reset are still in flight: keep them
      // counted as credit and mark them all stale. A reset held for two or
      // more cycles starts from a clean, empty bus.
      if (r_rst_q) begin
        r_out  <= {CW{1'b0}};
        r_disc <= {CW{1'b0}};
      end else begin
        r_out  <= w_out_next;
        r_disc <= w_out_next;
      end
    end else if (redirect_i) begin
      r_req_pc  <= w_redirect_pc;
      r_resp_pc <= w_redirect_pc;
      r_out     <= w_out_next;
      r_disc    <= w_out_next;
      r_cnt     <= {CW{1'b0}};
      r_rd_ptr  <= {PW{1'b0}};
      r_wr_ptr  <= {PW{1'b0}};
    end else begin
      r_out <= w_out_next;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_grant) begin
        r_req_pc <= r_req_pc + 32'd4;
      end
      if (w_drop) begin
        r_disc <= r_disc - CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // FIFO storage; written only by a response belonging to the current stream.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      r_fifo_instr[r_wr_ptr] <= imem.imem_rdata_i;
    end
  end

  // Head presentation to IF/ID; an empty FIFO shows a NOP at PC 0.
  always_comb begin
    if_valid_o = w_valid;
    if (w_valid) begin
      if_pc_o    = r_fifo_pc[r_rd_ptr];
      if_instr_o = r_fifo_instr[r_rd_ptr];
    end else begin
      if_pc_o    = 32'h0000_0000;
      if_instr_o = NOP;
    end
    if_pc4_o = if_pc_o + 32'd4;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Count cycles where IF/ID would accept an instruction but none is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= 32'd0;
    end else if (!w_valid && !stall_i) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_bubble_cnt_o = r_bubble_cnt;
`endif

  if_fetch_unit_chk #(
    .BUF_DEPTH (BUF_DEPTH),
    .CW        (CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_rvalid (imem.imem_rvalid_i),
    .i_cnt    (r_cnt),
    .i_out    (r_out),
    .i_disc   (r_disc)
  );
endmodule
